// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised 2-read / 1-write register file.
// Two combinational read ports, one write port with optional same-cycle
// bypass, and a sequenced clear engine that zeroes one entry per cycle.
module regfile_2r1w #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_req,
    output logic             busy,
    output logic             wr_drop
);

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [AW:0]   LP_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    w_ptr_d;
    logic             r_wr_drop;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_wr_acc;
    logic             w_waddr_ok;
    logic             w_ra_ok;
    logic             w_rb_ok;

    assign w_waddr_ok = ({1'b0, waddr} < LP_DEPTH);
    assign w_ra_ok    = ({1'b0, raddr_a} < LP_DEPTH);
    assign w_rb_ok    = ({1'b0, raddr_b} < LP_DEPTH);
    // Writes only land while the clear engine is idle.
    assign w_wr_acc   = we && w_waddr_ok && (r_state == StIdle);

    assign busy    = (r_state == StClear);
    assign wr_drop = r_wr_drop;

    // Clear-engine next state: clr_req is only honoured from idle.
    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        unique case (r_state)
            StIdle: begin
                if (clr_req) begin
                    w_state_d = StClear;
                    w_ptr_d   = '0;
                end
            end
            StClear: begin
                if (r_ptr == LP_LAST) begin
                    w_state_d = StIdle;
                    w_ptr_d   = '0;
                end else begin
                    w_ptr_d = r_ptr + AW'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
                w_ptr_d   = '0;
            end
        endcase
    end

    // State, storage and drop flag; clearing takes precedence over writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_ptr     <= '0;
            r_wr_drop <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state   <= w_state_d;
            r_ptr     <= w_ptr_d;
            r_wr_drop <= we && !w_wr_acc;
            if (r_state == StClear) begin
                r_mem[r_ptr] <= '0;
            end else if (w_wr_acc) begin
                r_mem[waddr] <= wdata;
            end
        end
    end

    // Read port A: out-of-range reads return 0; only accepted writes bypass.
    always_comb begin
        rdata_a = '0;
        if (w_ra_ok) begin
            rdata_a = r_mem[raddr_a];
        end
        if ((BYPASS != 0) && w_wr_acc && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
    end

    // Read port B: identical to port A, fully independent.
    always_comb begin
        rdata_b = '0;
        if (w_rb_ok) begin
            rdata_b = r_mem[raddr_b];
        end
        if ((BYPASS != 0) && w_wr_acc && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised 2-read / 1-write register file with synchronous reset, optional write-to-read bypass, and a sequenced bulk-clear engine. It is the next generation of the team's 4×4 single-port register file and serves as general-purpose operand storage for small datapaths. Both read ports are combinational, so a datapath can fetch two operands and write back one result in the same cycle.

## Interface
- `WIDTH`, default 4: data width of each entry in bits.
- `DEPTH`, default 4: number of entries, ≥2. Non-power-of-two values are allowed.
- `BYPASS`, default 1: 1 forwards write data to a read port reading the same address in the same cycle; 0 means reads return stored contents only.
- `AW`, localparam `$clog2(DEPTH)`: address width.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `we` input 1: write enable.
- `waddr` input AW: write address.
- `wdata` input WIDTH: write data.
- `raddr_a` input AW: read port A address.
- `rdata_a` output WIDTH: read port A data, combinational.
- `raddr_b` input AW: read port B address.
- `rdata_b` output WIDTH: read port B data, combinational.
- `clr_req` input 1: request to zero all entries.
- `busy` output 1: clear sequence in progress, registered.
- `wr_drop` output 1: registered one-cycle pulse; the previous cycle's write was rejected.

## Operation
- **Storage:** DEPTH×WIDTH flip-flop array.
- **Reset:** a rising edge with `rst`=1 sets all entries, `busy`, `wr_drop` and the clear pointer to 0, and the FSM to IDLE.
- **Reset values of outputs:** `rdata_a`=`rdata_b`=0, `busy`=0, `wr_drop`=0.
- **Write acceptance:** a write is accepted when `we`=1, `waddr`<DEPTH and the FSM is in IDLE.
  - An accepted write stores `wdata` at `waddr` on the edge.
  - A write with `we`=1 that is not accepted changes no entry, and `wr_drop`=1 on the following cycle.
- **Reads:**
  - `rdata_x` = entry[`raddr_x`] when `raddr_x`<DEPTH; otherwise 0.
  - Ports A and B are fully independent and may use the same address.
  - With BYPASS=1, an accepted write in the current cycle whose `waddr` equals `raddr_x` drives `rdata_x` = `wdata`.
  - Rejected writes are never bypassed.
- **FSM states:**
  - IDLE: `busy`=0.
    - `clr_req`=1 at an edge moves the FSM to CLEAR with pointer 0.
    - A simultaneous accepted write still commits on that same edge, and is later overwritten by the clear.
  - CLEAR: `busy`=1.
    - Each edge writes 0 to entry[pointer] and increments the pointer.
    - On the edge that clears entry DEPTH-1, the FSM returns to IDLE and the pointer to 0.
  - `clr_req` while in CLEAR is ignored; it does not restart or extend the sequence.
- **Reads during CLEAR:** reads return current contents, so an entry already cleared reads 0 and an entry not yet cleared reads its old value.
- **Precedence:** `rst` > CLEAR sequencing > write.
  - `rst` asserted mid-clear aborts the sequence: everything returns to 0 and the FSM to IDLE.

## Timing
- **Write-to-read latency:**
  - 0 cycles with BYPASS=1, since the value is visible combinationally in the cycle of the write.
  - 1 cycle with BYPASS=0, since the value is visible after the write edge.
- **Clear sequence:**
  - `busy` rises the cycle after `clr_req` is sampled.
  - `busy` stays high for exactly DEPTH cycles.
  - Writes are accepted again in the first cycle after `busy` falls.
- **Clear completion:** all entries read 0 from the first cycle with `busy`=0 after the sequence.
- **`wr_drop` timing:** asserts the cycle after the rejected attempt, lasts 1 cycle per rejected attempt, and back-to-back rejected attempts hold it high.
- **Combinational path:** the only combinational path from inputs to outputs is `raddr`/`we`/`waddr`/`wdata` → `rdata`.

## Test plan
1. **Reset:** hold `rst` for 2 cycles, then read all addresses on both ports → all 0; `busy`=0; `wr_drop`=0.
2. **Write/dual read** (WIDTH=4, DEPTH=4): write 0xA→0, 0x5→3, then set `raddr_a`=0, `raddr_b`=3 → `rdata_a`=0xA, `rdata_b`=0x5. With `raddr_a`=`raddr_b`=3 → both ports read 0x5.
3. **Bypass:**
   - BYPASS=1: `we`=1, `waddr`=2, `wdata`=0x7, `raddr_a`=2 in the same cycle → `rdata_a`=0x7 before the edge.
   - BYPASS=0: same stimulus → old value before the edge, 0x7 after the edge.
4. **Clear:** fill entries with 0xF, pulse `clr_req`:
   - `busy` high for exactly 4 cycles.
   - Mid-sequence, entry 0 reads 0 while entry 3 still reads 0xF.
   - After the sequence, all entries read 0.
   - `clr_req` held high throughout does not extend `busy`.
5. **Write during clear:** `we`=1 with `wdata`=0x3 while `busy`=1 → entry unchanged, `wr_drop`=1 for exactly the next cycle, no bypass of 0x3. Simultaneous `clr_req` and a write in IDLE → the entry ends at 0.
6. **Reset mid-clear, out-of-range, and non-power-of-two:**
   - `rst` during cycle 2 of CLEAR → `busy`=0 next cycle and all entries 0.
   - DEPTH=5: a write to address 6 → dropped with `wr_drop`=1; a read of address 6 → 0.
   - DEPTH=5: clear holds `busy` high for 5 cycles.
